// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one 2-bit adder. A round-robin grant
// picks which operand pair enters a single-entry result register; the
// consumer drains it with a valid/ready handshake. done_cnt counts drains.
module adder_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_a,
  input  logic [1:0]       req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_a,
  input  logic [1:0]       req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [2:0]       res_sum,
  output logic             res_id,
  input  logic             res_ready,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       sum_reg, sum_next;
  logic             id_reg, id_next;
  logic             last_grant_reg, last_grant_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [1:0] valid_vec;
  logic [1:0] ready_vec;
  logic       grant_id;
  logic       slot_free;
  logic       transfer;
  logic       drain;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign valid_vec = {req1_valid, req0_valid};

  // A lone requester wins outright; on a tie the one not served last wins.
  assign grant_id = (&valid_vec) ? ~last_grant_reg : valid_vec[1];

  // The slot can take new operands when empty or being drained this cycle.
  assign slot_free = (state_reg == EMPTY) || res_ready;

  // Per-requester ready; held low during reset so nothing is accepted then.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = !rst && slot_free && valid_vec[gi] &&
                             (grant_id == 1'(gi));
    end
  endgenerate

  assign transfer = |ready_vec;
  assign drain    = (state_reg == FULL) && res_ready;

  // The single shared adder sees only the granted operands.
  assign sel_a = grant_id ? req1_a : req0_a;
  assign sel_b = grant_id ? req1_b : req0_b;

  // Next-state: load on transfer (even while draining), empty on a bare drain.
  always_comb begin
    state_next      = state_reg;
    sum_next        = sum_reg;
    id_next         = id_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    if (transfer) begin
      state_next      = FULL;
      sum_next        = {1'b0, sel_a} + {1'b0, sel_b};
      id_next         = grant_id;
      last_grant_next = grant_id;
    end else if (drain) begin
      state_next = EMPTY;
    end
    if (drain) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // State registers; reset discards any held result and favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= EMPTY;
      sum_reg        <= 3'd0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      sum_reg        <= sum_next;
      id_reg         <= id_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign res_valid  = (state_reg == FULL);
  assign res_sum    = sum_reg;
  assign res_id     = id_reg;
  assign done_cnt   = cnt_reg;

endmodule
